// File: rtl/div_result_bcd_pkg.sv
// Shared types and constants for the divider-result to BCD converter.
// Holds the FSM state encoding, the error fill nibble and default sizes.
package div_result_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] ERR_NIBBLE     = 4'hF;
    localparam int         DEFAULT_WIDTH  = 8;
    localparam int         DEFAULT_DIGITS = 3;

    // Double-dabble correction: a digit of 5 or more would overflow past 9 once doubled.
    function automatic logic [3:0] add3_if_ge5(input logic [3:0] digit);
        return (digit >= 4'd5) ? (digit + 4'd3) : digit;
    endfunction

endpackage

// File: rtl/div_result_bcd_bcd_dd_step.sv
// One combinational double-dabble step for a single operand:
// correct every BCD digit, then shift left pulling in the next binary bit.
module bcd_dd_step
    import div_result_bcd_pkg::*;
#(
    parameter int DIGITS = DEFAULT_DIGITS
) (
    input  logic [4*DIGITS-1:0] bcd_in,
    input  logic                bit_in,
    output logic [4*DIGITS-1:0] bcd_out
);

    logic [4*DIGITS-1:0] adjusted;

    always_comb begin
        adjusted = '0;
        for (int i = 0; i < DIGITS; i++) begin
            adjusted[4*i +: 4] = add3_if_ge5(bcd_in[4*i +: 4]);
        end
        bcd_out = {adjusted[4*DIGITS-2:0], bit_in};
    end

endmodule

// File: rtl/div_result_bcd.sv
// Converts an unsigned divider quotient/remainder pair to packed BCD,
// one double-dabble step per cycle, with divide-by-zero flagged as err and all-F digits.
module div_result_bcd
    import div_result_bcd_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int DIGITS = DEFAULT_DIGITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    quotient,
    input  logic [WIDTH-1:0]    remainder,
    input  logic [WIDTH-1:0]    divisor,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] q_bcd,
    output logic [4*DIGITS-1:0] r_bcd,
    output logic                err
);

    localparam int             BW        = 4 * DIGITS;
    localparam int             CW        = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST_STEP = CW'(WIDTH - 1);

    state_t          state;
    logic [CW-1:0]   step;
    logic [WIDTH-1:0] q_shift;
    logic [WIDTH-1:0] r_shift;
    logic [BW-1:0]   q_acc;
    logic [BW-1:0]   r_acc;
    logic [BW-1:0]   q_next;
    logic [BW-1:0]   r_next;

    bcd_dd_step #(.DIGITS(DIGITS)) u_q_step (
        .bcd_in  (q_acc),
        .bit_in  (q_shift[WIDTH-1]),
        .bcd_out (q_next)
    );

    bcd_dd_step #(.DIGITS(DIGITS)) u_r_step (
        .bcd_in  (r_acc),
        .bit_in  (r_shift[WIDTH-1]),
        .bcd_out (r_next)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Accumulators are private; q_bcd/r_bcd only change when a conversion finishes,
    // so the last result stays visible through CONV and IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            step    <= '0;
            q_shift <= '0;
            r_shift <= '0;
            q_acc   <= '0;
            r_acc   <= '0;
            q_bcd   <= '0;
            r_bcd   <= '0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (divisor == '0) begin
                            state <= DONE;
                            err   <= 1'b1;
                            q_bcd <= {DIGITS{ERR_NIBBLE}};
                            r_bcd <= {DIGITS{ERR_NIBBLE}};
                        end else begin
                            state   <= CONV;
                            q_shift <= quotient;
                            r_shift <= remainder;
                            q_acc   <= '0;
                            r_acc   <= '0;
                            step    <= '0;
                        end
                    end
                end
                CONV: begin
                    q_acc   <= q_next;
                    r_acc   <= r_next;
                    q_shift <= q_shift << 1;
                    r_shift <= r_shift << 1;
                    step    <= step + CW'(1);
                    if (step == LAST_STEP) begin
                        state <= DONE;
                        q_bcd <= q_next;
                        r_bcd <= r_next;
                        err   <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_result_bcd.sv
// Directed bench for div_result_bcd: hand-computed BCD results, latency,
// divide-by-zero, back-pressure and mid-conversion reset.
module tb_div_result_bcd;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] q_bcd;
    logic [11:0] r_bcd;
    logic        err;

    int checks;
    int failures;

    div_result_bcd dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q_bcd     (q_bcd),
        .r_bcd     (r_bcd),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Presents one result for a single edge, returning at the following falling edge.
    task automatic applyStimulus(input logic [7:0] q, input logic [7:0] r, input logic [7:0] d);
        quotient  = q;
        remainder = r;
        divisor   = d;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    task automatic waitDone(output int cycles, output bit ready_seen);
        cycles     = 0;
        ready_seen = 1'b0;
        while (!out_valid && cycles < 20) begin
            if (in_ready) ready_seen = 1'b1;
            @(negedge clk);
            cycles++;
        end
    endtask

    function automatic logic allDigitsLe9(input logic [11:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    initial begin
        int cycles;
        bit ready_seen;
        bit saw_valid;

        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        quotient  = '0;
        remainder = '0;
        divisor   = '0;

        // Reset, with in_valid asserted to show reset wins.
        @(negedge clk);
        in_valid = 1'b1;
        divisor  = 8'd0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        checkOutput("rst_in_ready",  32'(in_ready),  32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_q_bcd",     32'(q_bcd),     32'h000);
        checkOutput("rst_r_bcd",     32'(r_bcd),     32'h000);
        checkOutput("rst_err",       32'(err),       32'd0);

        // Scenario 1: 4 r 0
        applyStimulus(8'd4, 8'd0, 8'd2);
        waitDone(cycles, ready_seen);
        checkOutput("s1_latency", 32'(cycles), 32'd8);
        checkOutput("s1_q_bcd",   32'(q_bcd),  32'h004);
        checkOutput("s1_r_bcd",   32'(r_bcd),  32'h000);
        checkOutput("s1_err",     32'(err),    32'd0);
        @(negedge clk);
        checkOutput("s1_back_idle",  32'(in_ready),  32'd1);
        checkOutput("s1_valid_drop", 32'(out_valid), 32'd0);
        checkOutput("s1_q_retained", 32'(q_bcd),     32'h004);

        // Scenario 2: 3 r 1, in_ready low throughout CONV
        applyStimulus(8'd3, 8'd1, 8'd3);
        waitDone(cycles, ready_seen);
        checkOutput("s2_latency",    32'(cycles),     32'd8);
        checkOutput("s2_ready_conv", 32'(ready_seen), 32'd0);
        checkOutput("s2_q_bcd",      32'(q_bcd),      32'h003);
        checkOutput("s2_r_bcd",      32'(r_bcd),      32'h001);
        checkOutput("s2_err",        32'(err),        32'd0);
        @(negedge clk);

        // Scenario 3: maximum quotient
        applyStimulus(8'd255, 8'd254, 8'd1);
        waitDone(cycles, ready_seen);
        checkOutput("s3_latency",  32'(cycles),               32'd8);
        checkOutput("s3_q_bcd",    32'(q_bcd),                32'h255);
        checkOutput("s3_r_bcd",    32'(r_bcd),                32'h254);
        checkOutput("s3_q_digits", 32'(allDigitsLe9(q_bcd)),  32'd1);
        checkOutput("s3_r_digits", 32'(allDigitsLe9(r_bcd)),  32'd1);
        checkOutput("s3_err",      32'(err),                  32'd0);
        @(negedge clk);

        // Scenario 4: divide by zero
        applyStimulus(8'd77, 8'd12, 8'd0);
        waitDone(cycles, ready_seen);
        checkOutput("s4_latency", 32'(cycles), 32'd0);
        checkOutput("s4_err",     32'(err),    32'd1);
        checkOutput("s4_q_bcd",   32'(q_bcd),  32'hFFF);
        checkOutput("s4_r_bcd",   32'(r_bcd),  32'hFFF);
        @(negedge clk);
        checkOutput("s4_back_idle", 32'(in_ready), 32'd1);

        // Scenario 5: back-pressure in DONE while a new input is offered
        out_ready = 1'b0;
        applyStimulus(8'd42, 8'd5, 8'd7);
        waitDone(cycles, ready_seen);
        checkOutput("s5_latency", 32'(cycles), 32'd8);
        quotient  = 8'd99;
        remainder = 8'd98;
        divisor   = 8'd0;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput($sformatf("s5_hold_valid_%0d", i), 32'(out_valid), 32'd1);
            checkOutput($sformatf("s5_hold_q_%0d", i),     32'(q_bcd),     32'h042);
            checkOutput($sformatf("s5_hold_r_%0d", i),     32'(r_bcd),     32'h005);
            checkOutput($sformatf("s5_hold_err_%0d", i),   32'(err),       32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("s5_idle_ready", 32'(in_ready),  32'd1);
        checkOutput("s5_idle_valid", 32'(out_valid), 32'd0);
        checkOutput("s5_q_retained", 32'(q_bcd),     32'h042);
        checkOutput("s5_err_kept",   32'(err),       32'd0);
        saw_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1'b1;
        end
        checkOutput("s5_ignored_input", 32'(saw_valid), 32'd0);

        // Scenario 6: reset on the 4th CONV edge
        applyStimulus(8'd123, 8'd45, 8'd9);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("s6_in_ready",  32'(in_ready),  32'd1);
        checkOutput("s6_out_valid", 32'(out_valid), 32'd0);
        checkOutput("s6_q_bcd",     32'(q_bcd),     32'h000);
        checkOutput("s6_r_bcd",     32'(r_bcd),     32'h000);
        checkOutput("s6_err",       32'(err),       32'd0);
        saw_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1'b1;
        end
        checkOutput("s6_no_valid", 32'(saw_valid), 32'd0);

        // Conversion after the abort still works from a clean start.
        applyStimulus(8'd100, 8'd9, 8'd2);
        waitDone(cycles, ready_seen);
        checkOutput("s7_latency", 32'(cycles), 32'd8);
        checkOutput("s7_q_bcd",   32'(q_bcd),  32'h100);
        checkOutput("s7_r_bcd",   32'(r_bcd),  32'h009);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_result_bcd.md
DIV_RESULT_BCD -- requirements
Module: div_result_bcd

Interface
REQ-001 Parameter: WIDTH, 8, binary width of the quotient and remainder inputs.
REQ-002 Parameter: DIGITS, 3, BCD digits per converted value; it SHALL satisfy 10^DIGITS > 2^WIDTH-1.
REQ-003 Port: clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 Port: rst_n  in  1  reset, synchronous, active-low.
REQ-005 Port: in_valid  in  1  upstream divider result present.
REQ-006 Port: in_ready  out  1  block can accept a result.
REQ-007 Port: quotient  in  WIDTH  divider quotient (unsigned).
REQ-008 Port: remainder  in  WIDTH  divider remainder (unsigned).
REQ-009 Port: divisor  in  WIDTH  divisor B that produced the result; used only for divide-by-zero detection.
REQ-010 Port: out_valid  out  1  converted result present.
REQ-011 Port: out_ready  in  1  downstream consumer accepts the result.
REQ-012 Port: q_bcd  out  4*DIGITS  quotient in packed BCD, most significant digit in the top nibble.
REQ-013 Port: r_bcd  out  4*DIGITS  remainder in packed BCD, same packing.
REQ-014 Port: err  out  1  result came from a divide-by-zero.

Function
REQ-015 FSM states SHALL be IDLE, CONV and DONE; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-016 Acceptance SHALL occur on an edge with state==IDLE and in_valid==1; quotient, remainder and divisor==0 SHALL be captured on that edge.
REQ-017 On acceptance with divisor!=0, the FSM SHALL go to CONV, clear both BCD accumulators and clear a step counter.
REQ-018 In CONV, each edge SHALL perform one double-dabble step on quotient and remainder in parallel:
- add 3 to every BCD digit >=5
- then shift left one bit, taking the next binary MSB.
REQ-019 After exactly WIDTH CONV edges, the FSM SHALL enter DONE, so out_valid rises WIDTH cycles after the acceptance edge (8 for default).
REQ-020 On acceptance with divisor==0, the FSM SHALL go directly to DONE on that edge with:
- err=1
- q_bcd = all nibbles 4'hF
- r_bcd = all nibbles 4'hF
REQ-021 On a non-zero-divisor result, err SHALL be 0 in DONE.
REQ-022 In DONE, q_bcd, r_bcd and err SHALL hold stable while out_ready==0, for any number of cycles.
REQ-023 The FSM SHALL return to IDLE on the edge where state==DONE and out_ready==1; outputs SHALL retain their last value until the next result is produced.
REQ-024 Inputs presented while in_ready==0 SHALL be ignored and have no effect on state or outputs; there SHALL be no overlap of results.
REQ-025 No BCD digit output SHALL ever exceed 9 for a non-error result, including quotient=2^WIDTH-1.
REQ-026 Throughput SHALL be one result per WIDTH+2 cycles with out_ready held high.

Reset
REQ-027 When rst_n==0 at a rising edge, the following SHALL hold after that edge:
- state = IDLE
- step counter = 0
- in_ready = 1
- out_valid = 0
- q_bcd = 0
- r_bcd = 0
- err = 0
REQ-028 Reset asserted during CONV or DONE SHALL abort the operation with no out_valid pulse for the aborted result.
REQ-029 Reset SHALL take priority over simultaneous in_valid or out_ready.

Structure
REQ-030 A shared package SHALL hold the FSM state enumeration, the error-nibble constant 4'hF and the default WIDTH/DIGITS constants.
REQ-031 One sub-module, bcd_dd_step, SHALL implement a single combinational add-3-then-shift step for one operand; it SHALL be instantiated twice, once for the quotient and once for the remainder.

Verification
REQ-032 Directed scenario 1: quotient=4, remainder=0, divisor=2, accepted -> after 8 cycles out_valid=1, q_bcd=12'h004, r_bcd=12'h000, err=0.
REQ-033 Directed scenario 2: quotient=3, remainder=1, divisor=3 -> q_bcd=12'h003, r_bcd=12'h001, err=0, and in_ready=0 throughout CONV.
REQ-034 Directed scenario 3: quotient=255, remainder=254, divisor=1 -> q_bcd=12'h255, r_bcd=12'h254, with all digits <=9.
REQ-035 Directed scenario 4: divisor=0, any quotient -> out_valid=1 one cycle after acceptance, err=1, q_bcd=r_bcd=12'hFFF.
REQ-036 Directed scenario 5: out_ready held 0 for 5 cycles in DONE while a new in_valid is presented ->
- outputs stay stable
- the new input is ignored
- IDLE is re-entered on the first out_ready=1 edge.
REQ-037 Directed scenario 6: rst_n=0 at the 4th CONV cycle -> next cycle in IDLE, all outputs 0, and no out_valid for the aborted result.
